// File: rtl/char_pkg.sv
// Shared definitions for the character case-conversion path: the character type,
// the ASCII lowercase bounds used by the converter, and the serial shift helper.
package char_pkg;

    localparam int CHAR_W = 8;

    typedef logic [CHAR_W-1:0] char_t;

    localparam char_t ASCII_LC_A = 8'h61;
    localparam char_t ASCII_LC_Z = 8'h7A;

    // MSB-first shifts left so the first bit lands in bit 7; LSB-first shifts right
    // so the first bit lands in bit 0.
    function automatic char_t shift_in(input char_t cur, input logic b, input bit msbFirst);
        if (msbFirst) begin
            return {cur[CHAR_W-2:0], b};
        end
        return {b, cur[CHAR_W-1:1]};
    endfunction

endpackage

// File: rtl/char_fifo.sv
// Synchronous FIFO with wrap-bit pointers; the head is presented combinationally and
// the last popped value is held while empty so the output never glitches.
module char_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   fill_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]        wrPtr_q, wrPtr_d;
    logic [AW:0]        rdPtr_q, rdPtr_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   lastOut_q;
    logic               doPush;
    logic               doPop;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
    assign fill_o  = wrPtr_q - rdPtr_q;

    // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);

    assign rdata_o = empty_o ? lastOut_q : mem_q[rdPtr_q[AW-1:0]];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + {{AW{1'b0}}, 1'b1};
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            lastOut_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            if (doPush) begin
                mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
            end
            if (doPop) begin
                lastOut_q <= mem_q[rdPtr_q[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/char_deser.sv
// Bit-serial to byte-parallel front end for the case converter: assembles bytes,
// buffers them in char_fifo and presents them with a valid/ready handshake.
module char_deser
    import char_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            bit_in,
    input  logic                            bit_valid,
    input  logic                            sof,
    output logic [CHAR_W-1:0]               byte_out,
    output logic                            byte_valid,
    input  logic                            byte_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fill,
    output logic                            overflow,
    output logic [15:0]                     byte_count
);

    localparam bit MSB_FIRST_B = (MSB_FIRST != 0);

    logic [2:0]     bitCnt_q, bitCnt_d;
    char_t          shift_q, shift_d;
    logic           overflow_q, overflow_d;
    logic [15:0]    count_q, count_d;
    logic           complete;
    logic           fifoFull;
    logic           fifoEmpty;
    logic           popReq;
    logic           pushOk;
    logic           dropByte;

    // sof wins over byte completion; with a valid bit it seeds the new byte.
    always_comb begin
        bitCnt_d = bitCnt_q;
        shift_d  = shift_q;
        complete = 1'b0;
        if (sof) begin
            if (bit_valid) begin
                shift_d  = shift_in('0, bit_in, MSB_FIRST_B);
                bitCnt_d = 3'd1;
            end else begin
                shift_d  = '0;
                bitCnt_d = 3'd0;
            end
        end else if (bit_valid) begin
            shift_d  = shift_in(shift_q, bit_in, MSB_FIRST_B);
            bitCnt_d = bitCnt_q + 3'd1;
            complete = (bitCnt_q == 3'd7);
        end
    end

    assign popReq   = byte_ready && !fifoEmpty;
    assign pushOk   = complete && (!fifoFull || popReq);
    assign dropByte = complete && fifoFull && !popReq;

    always_comb begin
        overflow_d = overflow_q || dropByte;
        count_d    = count_q + {15'd0, pushOk};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitCnt_q   <= '0;
            shift_q    <= '0;
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else begin
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
        end
    end

    char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CHAR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pushOk),
        .wdata_i (shift_d),
        .pop_i   (popReq),
        .rdata_o (byte_out),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .fill_o  (fill)
    );

    assign byte_valid = !fifoEmpty;
    assign overflow   = overflow_q;
    assign byte_count = count_q;

endmodule

// File: tb/tb_char_deser.sv
// Self-checking bench for char_deser: one MSB-first and one LSB-first instance share the
// serial stimulus, and popped bytes are compared against per-instance scoreboard queues.
module tb_char_deser;

    localparam int DEPTH = 4;
    localparam int FW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [7:0] serial;
        logic [7:0] expMsb;
        logic [7:0] expLsb;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          bitIn;
    logic          bitValid;
    logic          sof;
    logic          byteReady;

    logic [7:0]    byteOutM, byteOutL;
    logic          byteValidM, byteValidL;
    logic [FW-1:0] fillM, fillL;
    logic          overflowM, overflowL;
    logic [15:0]   countM, countL;

    int            checks   = 0;
    int            failures = 0;
    logic [7:0]    qMsb[$];
    logic [7:0]    qLsb[$];
    vec_t          vecs[7];

    always #5 clk = ~clk;

    char_deser #(.FIFO_DEPTH(DEPTH), .MSB_FIRST(1)) dutMsb (
        .clk(clk), .rst(rst), .bit_in(bitIn), .bit_valid(bitValid), .sof(sof),
        .byte_out(byteOutM), .byte_valid(byteValidM), .byte_ready(byteReady),
        .fill(fillM), .overflow(overflowM), .byte_count(countM)
    );

    char_deser #(.FIFO_DEPTH(DEPTH), .MSB_FIRST(0)) dutLsb (
        .clk(clk), .rst(rst), .bit_in(bitIn), .bit_valid(bitValid), .sof(sof),
        .byte_out(byteOutL), .byte_valid(byteValidL), .byte_ready(byteReady),
        .fill(fillL), .overflow(overflowL), .byte_count(countL)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    // Drive one sampled bit for exactly one rising edge.
    task automatic applyStimulus(input logic b, input logic s);
        bitIn    = b;
        bitValid = 1'b1;
        sof      = s;
        @(posedge clk);
        #1;
        bitValid = 1'b0;
        sof      = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] serial, input bit kept);
        for (int i = 7; i >= 0; i--) begin
            applyStimulus(serial[i], 1'b0);
        end
        if (kept) begin
            qMsb.push_back(serial);
            qLsb.push_back(rev8(serial));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drainWait(input string name);
        int n = 0;
        while ((qMsb.size() != 0 || qLsb.size() != 0) && n < 60) begin
            idle(1);
            n++;
        end
        checkOutput(name, qMsb.size() + qLsb.size(), 0);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, " valid"},    {byteValidM, byteValidL}, 2'b00);
        checkOutput({tag, " fill"},     {fillM, fillL},           '0);
        checkOutput({tag, " overflow"}, {overflowM, overflowL},   2'b00);
        checkOutput({tag, " count"},    {countM, countL},         32'd0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        qMsb.delete();
        qLsb.delete();
        idle(1);
    endtask

    // Scoreboard monitors: a transfer is due on the next edge when valid && ready mid-cycle.
    always @(negedge clk) begin
        if (!rst && byteValidM && byteReady) begin
            if (qMsb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL msb unexpected byte: got 0x%0h, expected none", byteOutM);
            end else begin
                checkOutput("msb popped byte", byteOutM, qMsb.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && byteValidL && byteReady) begin
            if (qLsb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL lsb unexpected byte: got 0x%0h, expected none", byteOutL);
            end else begin
                checkOutput("lsb popped byte", byteOutL, qLsb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{8'b0110_0001, 8'h61, 8'h86};
        vecs[1] = '{8'b1000_0110, 8'h86, 8'h61};
        vecs[2] = '{8'h28,        8'h28, 8'h14};
        vecs[3] = '{8'hFF,        8'hFF, 8'hFF};
        vecs[4] = '{8'h00,        8'h00, 8'h00};
        vecs[5] = '{8'h0F,        8'h0F, 8'hF0};
        vecs[6] = '{8'h12,        8'h12, 8'h48};

        rst = 1'b1; bitIn = 1'b0; bitValid = 1'b0; sof = 1'b0; byteReady = 1'b0;
        #3;
        checkOutput("reset byte_out", {byteOutM, byteOutL}, 16'h0000);
        checkCleared("reset");
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // First byte with the consumer ready: one cycle latency, popped on the next edge.
        byteReady = 1'b1;
        sendByte(8'b0110_0001, 1'b1);
        checkOutput("first byte valid", {byteValidM, byteValidL}, 2'b11);
        checkOutput("first byte msb",   byteOutM, 8'h61);
        checkOutput("first byte lsb",   byteOutL, 8'h86);
        checkOutput("first byte count", countM, 16'd1);
        idle(1);
        checkOutput("first byte drained fill", fillM, '0);
        checkOutput("first byte drained valid", byteValidM, 1'b0);

        for (int i = 0; i < 7; i++) begin
            for (int b = 7; b >= 0; b--) begin
                applyStimulus(vecs[i].serial[b], 1'b0);
            end
            qMsb.push_back(vecs[i].expMsb);
            qLsb.push_back(vecs[i].expLsb);
        end
        drainWait("table drain");
        checkOutput("table count", {countM, countL}, {16'd8, 16'd8});

        // Partial byte followed by sof without a bit: the three bits are discarded.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        sof = 1'b1;
        idle(1);
        sof = 1'b0;
        sendByte(8'h28, 1'b1);
        drainWait("sof drain");
        checkOutput("sof count", countM, 16'd9);

        // sof with a valid bit: that bit becomes bit #0 of the new byte.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        for (int b = 6; b >= 0; b--) begin
            applyStimulus(8'h5A >> b, 1'b0);
        end
        qMsb.push_back(8'h5A);
        qLsb.push_back(rev8(8'h5A));
        drainWait("sof-bit drain");
        checkOutput("sof-bit count", countM, 16'd10);

        // Fill the FIFO, then complete a byte on the same edge as a pop.
        byteReady = 1'b0;
        sendByte(8'h10, 1'b1);
        sendByte(8'h20, 1'b1);
        sendByte(8'h30, 1'b1);
        sendByte(8'h40, 1'b1);
        checkOutput("full fill", fillM, 4);
        checkOutput("full head", byteOutM, 8'h10);
        for (int b = 7; b >= 1; b--) begin
            applyStimulus(8'h50 >> b, 1'b0);
        end
        byteReady = 1'b1;
        applyStimulus(1'b0, 1'b0);
        qMsb.push_back(8'h50);
        qLsb.push_back(rev8(8'h50));
        checkOutput("push+pop fill", {fillM, fillL}, {3'd4, 3'd4});
        checkOutput("push+pop overflow", overflowM, 1'b0);
        checkOutput("push+pop count", countM, 16'd15);
        drainWait("push+pop drain");

        // Overflow: fifth byte is dropped and the flag sticks.
        doReset();
        byteReady = 1'b0;
        for (int v = 8'h41; v <= 8'h45; v++) begin
            sendByte(8'(v), v != 8'h45);
        end
        checkOutput("overflow fill", fillM, 4);
        checkOutput("overflow flag", {overflowM, overflowL}, 2'b11);
        checkOutput("overflow count", countM, 16'd4);
        idle(2);
        checkOutput("stall stable out", byteOutM, 8'h41);
        checkOutput("stall stable valid", byteValidM, 1'b1);
        byteReady = 1'b1;
        drainWait("overflow drain");
        checkOutput("overflow sticky", overflowM, 1'b1);
        checkOutput("overflow empty", fillM, '0);

        // Asynchronous reset mid-cycle with buffered data and a partial byte.
        doReset();
        byteReady = 1'b0;
        sendByte(8'h33, 1'b0);
        sendByte(8'h44, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkCleared("async reset");
        rst = 1'b0;
        qMsb.delete();
        qLsb.delete();
        idle(1);
        byteReady = 1'b1;
        sendByte(8'h61, 1'b1);
        checkOutput("post-reset msb", byteOutM, 8'h61);
        checkOutput("post-reset lsb", byteOutL, 8'h86);
        drainWait("post-reset drain");
        checkOutput("post-reset count", countM, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/char_deser.md
Name: char_deser

Overview:
- Bit-serial to byte-parallel front end for the character case-conversion path.
- Sits directly upstream of the 8-bit combinational converter and drives its eight character inputs.
- Assembles serial bits into bytes and buffers them in a small FIFO.
- Presents bytes with a valid/ready handshake so the converter-side consumer can stall without losing characters.

Parameters:
- FIFO_DEPTH, 4, number of buffered bytes; power of 2, minimum 2.
- MSB_FIRST, 1, 1: first serial bit lands in byte_out[7] (converter MSB input); 0: first bit lands in byte_out[0].

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is sampled on this cycle.
- sof  input  1  start-of-frame; discards any partial byte and resynchronises the bit counter.
- byte_out  output  8  head-of-FIFO byte, wired to the converter inputs (bit 7 = MSB).
- byte_valid  output  1  byte_out holds a valid byte.
- byte_ready  input  1  consumer accepts byte_out this cycle.
- fill  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; a completed byte was dropped because the FIFO was full.
- byte_count  output  16  count of bytes written into the FIFO; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (async assert, sync release) clears all state and outputs:
  - byte_out = 8'h00, byte_valid = 0, fill = 0, overflow = 0, byte_count = 0.
  - Bit counter = 0, shift register = 0, FIFO pointers = 0.
  - Reset mid-byte or with a non-empty FIFO discards all data.
- Shift stage:
  - 3-bit counter plus 8-bit shift register; advances only when bit_valid = 1.
  - MSB_FIRST = 1: register shifts left and the new bit enters bit 0, so the first bit ends up in bit 7.
  - MSB_FIRST = 0: register shifts right and the new bit enters bit 7.
  - A byte is complete when bit_valid = 1 and counter = 7. The counter then wraps to 0.
- sof handling:
  - sof = 1 with bit_valid = 0: counter goes to 0 and the partial byte is discarded.
  - sof = 1 with bit_valid = 1: counter restarts, and this bit becomes bit #0 of the new byte (counter = 1 afterwards).
  - sof has priority over byte completion, so no push happens that cycle.
- Push:
  - A completed byte is written into the FIFO on the same edge the 8th bit is sampled.
  - It appears at byte_out with byte_valid = 1 on the next cycle if the FIFO was empty (latency 1 cycle from the 8th bit_valid).
  - byte_count increments on every successful push.
- Pop: occurs when byte_valid && byte_ready. The head advances on that edge.
- Output stability: while byte_valid = 1 and byte_ready = 0, byte_out and byte_valid stay stable. byte_out is don't-care-but-stable (last value) when byte_valid = 0.
- Full FIFO:
  - A push and pop in the same cycle are both accepted and fill is unchanged.
  - A push with no pop is dropped: overflow is set to 1 (sticky until rst), and byte_count does not increment.
- Empty FIFO: byte_ready is ignored. A pop never occurs on an empty FIFO; a push into an empty FIFO does not bypass the register stage.
- Pointer wrap: read and write pointers are log2(FIFO_DEPTH) bits plus a wrap bit. Full = indices equal and wrap bits differ.

Decomposition:
- Shared package char_pkg holds:
  - CHAR_W = 8.
  - typedef char_t (logic [7:0]).
  - Constants ASCII_LC_A = 8'h61 and ASCII_LC_Z = 8'h7A, shared with the converter stage.
- One natural sub-module: char_fifo, a synchronous FIFO parameterised by depth and width.
  - Provides push/pop, full/empty and fill.
  - char_deser instantiates it and keeps the shift/counter/sof logic at the top level.

Test Plan:
- Reset, then 8 serial bits 0,1,1,0,0,0,0,1 (MSB_FIRST = 1), byte_ready = 1 -> one cycle after the 8th bit: byte_valid = 1, byte_out = 8'h61, byte_count = 1. Popped on the next edge, fill returns to 0.
- Three bits 1,1,1, then sof with bit_valid = 0, then bits for 8'h28 -> only 8'h28 is emitted; the partial 3 bits never appear.
- byte_ready = 0, push 5 bytes 8'h41..8'h45 with FIFO_DEPTH = 4 -> fill = 4, overflow = 1, byte_count = 4. Then byte_ready = 1 -> outputs 41,42,43,44 in order; 45 is lost.
- FIFO full with byte_ready = 1 held while the 8th bit of a new byte arrives -> simultaneous push/pop, fill stays 4, overflow stays 0.
- Byte stream in progress with a non-empty FIFO, assert rst asynchronously mid-cycle -> byte_valid = 0, fill = 0, byte_count = 0 immediately. The first byte after release is assembled from bit #0.
- MSB_FIRST = 0 build: bits 1,0,0,0,0,1,1,0 -> byte_out = 8'h61.
